// File: rtl/pwm_capture.sv
// Three-channel servo PWM decoder: synchronise, glitch-filter and measure
// high time and rising-to-rising period of each input in clk cycles.
module pwm_capture #(
  parameter int unsigned FRAME_CYC   = 2000000,
  parameter int unsigned TIMEOUT_CYC = 5000000,
  parameter int unsigned FILT        = 4,
  parameter int unsigned MIN_W       = 50000,
  parameter int unsigned MAX_W       = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in1,
  input  logic        pwm_in2,
  input  logic        pwm_in3,
  output logic [31:0] width1,
  output logic [31:0] width2,
  output logic [31:0] width3,
  output logic [31:0] period1,
  output logic [31:0] period2,
  output logic [31:0] period3,
  output logic [2:0]  valid,
  output logic [2:0]  range_err,
  output logic [2:0]  lost
);

  localparam int FCW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // A frame shorter than the longest legal pulse cannot carry a servo command.
  if (FILT < 1 || FRAME_CYC <= MAX_W) begin : g_param_check
    $error("pwm_capture: FILT must be >= 1 and FRAME_CYC must exceed MAX_W");
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [2:0]  pwm_vec;
  logic [31:0] width_arr  [3];
  logic [31:0] period_arr [3];

  assign pwm_vec = {pwm_in3, pwm_in2, pwm_in1};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [1:0]     sync_reg;
      logic           filt_reg;
      logic           filt_d_reg;
      logic [FCW-1:0] run_reg;
      logic [1:0]     settle_reg;
      logic           armed_reg;

      logic           rise;
      logic           fall;
      logic           edge_seen;
      logic           timeout;

      state_t         state_reg, state_next;
      logic [31:0]    hcnt_reg, hcnt_next;
      logic [31:0]    pcnt_reg, pcnt_next;
      logic [31:0]    idle_reg, idle_next;
      logic [31:0]    width_reg, width_next;
      logic [31:0]    period_reg, period_next;
      logic           valid_reg, valid_next;
      logic           rerr_reg, rerr_next;
      logic           lost_reg, lost_next;

      assign rise      = filt_reg & ~filt_d_reg;
      assign fall      = ~filt_reg & filt_d_reg;
      assign edge_seen = rise | fall;
      assign timeout   = ~edge_seen && (sat_inc(idle_reg) >= TIMEOUT_CYC);

      // Front end: synchroniser, run-length glitch filter, edge delay.
      // armed_reg blocks measuring a pulse that was already high at reset
      // release: it needs a genuine low level or a filtered fall first.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_reg   <= 2'b00;
          filt_reg   <= 1'b0;
          filt_d_reg <= 1'b0;
          run_reg    <= '0;
          settle_reg <= 2'd0;
          armed_reg  <= 1'b0;
        end else begin
          sync_reg   <= {sync_reg[0], pwm_vec[gi]};
          filt_d_reg <= filt_reg;
          if (sync_reg[1] != filt_reg) begin
            if (run_reg == FCW'(FILT - 1)) begin
              filt_reg <= sync_reg[1];
              run_reg  <= '0;
            end else begin
              run_reg <= run_reg + FCW'(1);
            end
          end else begin
            run_reg <= '0;
          end
          if (settle_reg != 2'd2) begin
            settle_reg <= settle_reg + 2'd1;
          end
          if (fall || (settle_reg == 2'd2 && !sync_reg[1] && !filt_reg)) begin
            armed_reg <= 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg  <= ST_WAIT;
          hcnt_reg   <= '0;
          pcnt_reg   <= '0;
          idle_reg   <= '0;
          width_reg  <= '0;
          period_reg <= '0;
          valid_reg  <= 1'b0;
          rerr_reg   <= 1'b0;
          lost_reg   <= 1'b0;
        end else begin
          state_reg  <= state_next;
          hcnt_reg   <= hcnt_next;
          pcnt_reg   <= pcnt_next;
          idle_reg   <= idle_next;
          width_reg  <= width_next;
          period_reg <= period_next;
          valid_reg  <= valid_next;
          rerr_reg   <= rerr_next;
          lost_reg   <= lost_next;
        end
      end

      always_comb begin
        state_next  = state_reg;
        hcnt_next   = sat_inc(hcnt_reg);
        pcnt_next   = sat_inc(pcnt_reg);
        idle_next   = edge_seen ? 32'd0 : sat_inc(idle_reg);
        width_next  = width_reg;
        period_next = period_reg;
        valid_next  = 1'b0;
        rerr_next   = rerr_reg;
        lost_next   = lost_reg;

        case (state_reg)
          ST_WAIT: begin
            hcnt_next = hcnt_reg;
            pcnt_next = pcnt_reg;
            if (rise && armed_reg) begin
              hcnt_next  = 32'd1;
              pcnt_next  = 32'd1;
              state_next = ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (fall) begin
              width_next = hcnt_reg;
              valid_next = 1'b1;
              rerr_next  = (hcnt_reg < MIN_W) || (hcnt_reg > MAX_W);
              lost_next  = 1'b0;
              state_next = ST_LOW;
            end
          end
          ST_LOW: begin
            if (rise) begin
              period_next = pcnt_reg;
              hcnt_next   = 32'd1;
              pcnt_next   = 32'd1;
              state_next  = ST_HIGH;
            end
          end
          default: begin
            state_next = ST_WAIT;
          end
        endcase

        // Only fires with no edge this cycle, so a coincident fall still publishes.
        if (timeout) begin
          lost_next  = 1'b1;
          state_next = ST_WAIT;
          idle_next  = 32'd0;
        end
      end

      assign width_arr[gi]  = width_reg;
      assign period_arr[gi] = period_reg;
      assign valid[gi]      = valid_reg;
      assign range_err[gi]  = rerr_reg;
      assign lost[gi]       = lost_reg;
    end
  endgenerate

  assign width1  = width_arr[0];
  assign width2  = width_arr[1];
  assign width3  = width_arr[2];
  assign period1 = period_arr[0];
  assign period2 = period_arr[1];
  assign period3 = period_arr[2];

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture with scaled-down timing: pulse-level waveforms are
// queued per channel, and expected publishes are derived from pulse geometry.
module tb_pwm_capture;

  localparam int TIMEOUT = 5000;
  localparam int FILT    = 4;
  localparam int MIN_W   = 50;
  localparam int MAX_W   = 250;
  localparam int FRAME   = 2000;
  localparam int LAT     = 3 + FILT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in1 = 1'b0;
  logic        pwm_in2 = 1'b0;
  logic        pwm_in3 = 1'b0;
  logic [31:0] width1, width2, width3;
  logic [31:0] period1, period2, period3;
  logic [2:0]  valid, range_err, lost;

  always #5 clk = ~clk;

  pwm_capture #(
    .FRAME_CYC  (FRAME),
    .TIMEOUT_CYC(TIMEOUT),
    .FILT       (FILT),
    .MIN_W      (MIN_W),
    .MAX_W      (MAX_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in1  (pwm_in1),
    .pwm_in2  (pwm_in2),
    .pwm_in3  (pwm_in3),
    .width1   (width1),
    .width2   (width2),
    .width3   (width3),
    .period1  (period1),
    .period2  (period2),
    .period3  (period3),
    .valid    (valid),
    .range_err(range_err),
    .lost     (lost)
  );

  logic [31:0] width_mon  [3];
  logic [31:0] period_mon [3];
  assign width_mon[0]  = width1;
  assign width_mon[1]  = width2;
  assign width_mon[2]  = width3;
  assign period_mon[0] = period1;
  assign period_mon[1] = period2;
  assign period_mon[2] = period3;

  typedef struct {
    int cyc;
    int width;
    int period;
    bit rerr;
  } ev_t;

  typedef struct {
    int cyc;
    int width;
  } cp_t;

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  rst_at = 0;
  bit  pin_q [3][$];
  ev_t ev_q  [3][$];
  cp_t cp_q  [3][$];
  int  last_edge [3];
  int  prev_rise [3];
  int  mdl_w [3];
  int  mdl_p [3];

  task automatic check(input string tag, input int ch, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s ch%0d cyc %0d: observed %0d expected %0d", tag, ch + 1, cyc, obs, exp);
    end
  endtask

  function automatic int pos(input int ch);
    return cyc + pin_q[ch].size();
  endfunction

  task automatic push(input int ch, input bit lvl, input int n);
    repeat (n) pin_q[ch].push_back(lvl);
  endtask

  task automatic align();
    int m;
    m = 0;
    for (int ch = 0; ch < 3; ch++) if (pin_q[ch].size() > m) m = pin_q[ch].size();
    for (int ch = 0; ch < 3; ch++) push(ch, 1'b0, m - pin_q[ch].size() + 20);
  endtask

  // One logical pulse: hi cycles high then lo cycles low, optionally with
  // sub-FILT glitches in the middle of each level that must be ignored.
  task automatic add_pulse(input int ch, input int hi, input int lo, input bit glitch);
    int  rise;
    ev_t ev;
    cp_t cp;
    rise = pos(ch);
    if (rise - last_edge[ch] > TIMEOUT - 50 && rise - last_edge[ch] < TIMEOUT + 50) begin
      push(ch, 1'b0, 100);
      rise = pos(ch);
    end
    if (rise - last_edge[ch] >= TIMEOUT) begin
      cp.cyc   = rise;
      cp.width = mdl_w[ch];
      cp_q[ch].push_back(cp);
      prev_rise[ch] = -1;
    end
    if (prev_rise[ch] >= 0) mdl_p[ch] = rise - prev_rise[ch];
    if (glitch) begin
      push(ch, 1'b1, hi / 2);
      push(ch, 1'b0, 3);
      push(ch, 1'b1, hi - hi / 2 - 3);
      push(ch, 1'b0, lo / 2);
      push(ch, 1'b1, 3);
      push(ch, 1'b0, lo - lo / 2 - 3);
    end else begin
      push(ch, 1'b1, hi);
      push(ch, 1'b0, lo);
    end
    mdl_w[ch]  = hi;
    ev.cyc     = rise + hi + LAT;
    ev.width   = hi;
    ev.period  = mdl_p[ch];
    ev.rerr    = (hi < MIN_W) || (hi > MAX_W);
    ev_q[ch].push_back(ev);
    prev_rise[ch] = rise;
    last_edge[ch] = rise + hi;
  endtask

  task automatic check_cycle();
    ev_t ev;
    cp_t cp;
    bit  exp_v;
    for (int ch = 0; ch < 3; ch++) begin
      exp_v = (ev_q[ch].size() > 0) && (ev_q[ch][0].cyc == cyc);
      if (cyc > 0) check("valid", ch, 32'(valid[ch]), 32'(exp_v));
      if (exp_v) begin
        ev = ev_q[ch].pop_front();
        check("width", ch, width_mon[ch], ev.width);
        check("period", ch, period_mon[ch], ev.period);
        check("range_err", ch, 32'(range_err[ch]), 32'(ev.rerr));
        check("lost_on_publish", ch, 32'(lost[ch]), 32'd0);
      end
      if (cp_q[ch].size() > 0 && cp_q[ch][0].cyc == cyc) begin
        cp = cp_q[ch].pop_front();
        check("lost_timeout", ch, 32'(lost[ch]), 32'd1);
        check("width_hold", ch, width_mon[ch], cp.width);
      end
      if (cyc > rst_at && cyc <= rst_at + 3) begin
        check("reset_width", ch, width_mon[ch], 32'd0);
        check("reset_period", ch, period_mon[ch], 32'd0);
        check("reset_valid", ch, 32'(valid[ch]), 32'd0);
        check("reset_range_err", ch, 32'(range_err[ch]), 32'd0);
        check("reset_lost", ch, 32'(lost[ch]), 32'd0);
      end
    end
  endtask

  task automatic play();
    while (pin_q[0].size() > 0 || pin_q[1].size() > 0 || pin_q[2].size() > 0) begin
      @(negedge clk);
      check_cycle();
      pwm_in1 = (pin_q[0].size() > 0) ? pin_q[0].pop_front() : 1'b0;
      pwm_in2 = (pin_q[1].size() > 0) ? pin_q[1].pop_front() : 1'b0;
      pwm_in3 = (pin_q[2].size() > 0) ? pin_q[2].pop_front() : 1'b0;
      rst_n   = !(cyc >= rst_at && cyc < rst_at + 2);
      cyc++;
    end
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    for (int ch = 0; ch < 3; ch++) begin
      last_edge[ch] = 0;
      prev_rise[ch] = -1;
      mdl_w[ch]     = 0;
      mdl_p[ch]     = 0;
    end

    // Reset at power-up, then nominal frames, glitchy pulses and range limits.
    for (int ch = 0; ch < 3; ch++) push(ch, 1'b0, 20);
    for (int i = 0; i < 3; i++) add_pulse(0, 156, FRAME - 156, 1'b0);
    for (int i = 0; i < 2; i++) add_pulse(1, 100, FRAME - 100, 1'b1);
    add_pulse(2, 40, 960, 1'b0);
    add_pulse(2, 260, 740, 1'b0);
    add_pulse(2, 250, 750, 1'b0);
    play();
    $display("phase nominal/glitch/range done at cyc %0d: checks %0d errors %0d", cyc, n_checks, n_errors);

    // Signal lost on ch1, then recovery without a period update.
    align();
    push(0, 1'b0, TIMEOUT + 500);
    add_pulse(0, 154, 846, 1'b0);
    play();
    $display("phase timeout done at cyc %0d: checks %0d errors %0d", cyc, n_checks, n_errors);

    // Reset in the middle of a high pulse on every channel.
    align();
    base   = pos(0);
    rst_at = base + 100;
    for (int ch = 0; ch < 3; ch++) begin
      push(ch, 1'b0, 30);
      push(ch, 1'b1, 170);
      push(ch, 1'b0, 50);
      last_edge[ch] = base + 200;
      prev_rise[ch] = -1;
      mdl_w[ch]     = 0;
      mdl_p[ch]     = 0;
      add_pulse(ch, 120, 880, 1'b0);
      add_pulse(ch, 120, 880, 1'b0);
    end
    play();
    $display("phase mid-pulse reset done at cyc %0d: checks %0d errors %0d", cyc, n_checks, n_errors);

    // Identical edges on all channels publish together.
    align();
    for (int i = 0; i < 2; i++)
      for (int ch = 0; ch < 3; ch++) add_pulse(ch, 157, 843, 1'b0);
    play();
    $display("phase simultaneous done at cyc %0d: checks %0d errors %0d", cyc, n_checks, n_errors);

    // Random widths and gaps, some out of range, some with glitches.
    align();
    for (int i = 0; i < 8; i++)
      for (int ch = 0; ch < 3; ch++)
        add_pulse(ch, int'($urandom_range(20, 300)), int'($urandom_range(20, 400)),
                  1'($urandom_range(0, 1)));
    push(0, 1'b0, 20);
    play();
    $display("phase random done at cyc %0d: checks %0d errors %0d", cyc, n_checks, n_errors);

    for (int ch = 0; ch < 3; ch++) begin
      check("pending_publish", ch, ev_q[ch].size(), 32'd0);
      check("pending_lost", ch, cp_q[ch].size(), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
